button_scheduler: RTL and testbench

BUTTON_SCHEDULER -- requirements
Module: button_scheduler

---
 rtl/button_scheduler.sv | 148 ++++++++++++++
 tb/tb_button_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_scheduler.sv
// button_scheduler
//   Arbitrates four debounced buttons onto one key-event stream. The lowest
//   pressed button (seen from IDLE) takes ownership; its press emits a single
//   key_pulse, holding it for HOLD_CYCLES edges emits long_press, and (with
//   AUTO_REPEAT_EN defined) continued holding emits a key_pulse every
//   REPEAT_CYCLES edges. All outputs are registered.
//
//   Build option: define AUTO_REPEAT_EN to enable auto-repeat pulses in HOLD.
//   The default build (macro undefined) only waits for release in HOLD.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no owner; waiting for any button
//   PRESS    | owner pressed, counting towards long press
//   HOLD     | long press reached; waiting for release (or auto-repeating)
//   WAIT_REL | waiting for all buttons released before re-arming
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   btn_clean   in   [3:0] debounced, clk-synchronous button levels
//   key_pulse   out  [3:0] one-cycle strobe, one-hot on the owning button
//   long_press  out  one-cycle strobe when the owner reaches HOLD_CYCLES
//   key_id      out  [1:0] owning button index while busy, 0 otherwise
//   busy        out  high in PRESS or HOLD

module button_scheduler #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_clean,
  output logic [3:0] key_pulse,
  output logic       long_press,
  output logic [1:0] key_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  // Both terminal counts must fit in the counter, otherwise the compare
  // could never match and the counter would wrap.
  localparam bit CNT_W_OK = (longint'(HOLD_CYCLES - 1)   < (longint'(1) << CNT_W)) &&
                            (longint'(REPEAT_CYCLES - 1) < (longint'(1) << CNT_W)) &&
                            (HOLD_CYCLES > 0) && (REPEAT_CYCLES > 0);

  generate
    if (!CNT_W_OK) begin : g_cfg_check
      $error("button_scheduler: CNT_W too small for HOLD_CYCLES/REPEAT_CYCLES");
    end
  endgenerate

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       first_id;
  logic             owner_held;

  // Lowest-index pressed button wins arbitration.
  always_comb begin
    first_id = 2'd0;
    if      (btn_clean[0]) first_id = 2'd0;
    else if (btn_clean[1]) first_id = 2'd1;
    else if (btn_clean[2]) first_id = 2'd2;
    else if (btn_clean[3]) first_id = 2'd3;
  end

  assign owner_held = btn_clean[key_id];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Reset lands in WAIT_REL so a button held through reset is not
      // reported until it has been released and pressed again.
      state      <= WAIT_REL;
      cnt        <= '0;
      key_pulse  <= 4'b0000;
      long_press <= 1'b0;
      key_id     <= 2'd0;
      busy       <= 1'b0;
    end else begin
      key_pulse  <= 4'b0000;
      long_press <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_clean != 4'b0000) begin
            key_id    <= first_id;
            key_pulse <= 4'b0001 << first_id;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= PRESS;
          end
        end
        PRESS: begin
          if (!owner_held) begin
            state  <= WAIT_REL;
            cnt    <= '0;
            busy   <= 1'b0;
            key_id <= 2'd0;
          end else if (cnt == HOLD_MAX) begin
            long_press <= 1'b1;
            cnt        <= '0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!owner_held) begin
            state  <= WAIT_REL;
            cnt    <= '0;
            busy   <= 1'b0;
            key_id <= 2'd0;
          end
`ifdef AUTO_REPEAT_EN
          else if (cnt == REPEAT_MAX) begin
            key_pulse <= 4'b0001 << key_id;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WAIT_REL: begin
          if (btn_clean == 4'b0000) state <= IDLE;
        end
        default: begin
          state  <= WAIT_REL;
          cnt    <= '0;
          busy   <= 1'b0;
          key_id <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_scheduler.sv
module tb_button_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_clean;
  logic [3:0] key_pulse;
  logic       long_press;
  logic [1:0] key_id;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  button_scheduler #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_clean (btn_clean),
    .key_pulse (key_pulse),
    .long_press(long_press),
    .key_id    (key_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_clean = 4'b0000;
    step();
    step();
    total++;
    if ({key_pulse, long_press, key_id, busy} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got pulse=%b long=%b id=%0d busy=%b, want all 0",
               key_pulse, long_press, key_id, busy);
    end
    rst_n = 1'b1;
    step();   // WAIT_REL sees 0 -> IDLE
    total++;
    if ({key_pulse, long_press, key_id, busy} !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: got pulse=%b long=%b id=%0d busy=%b, want all 0",
               key_pulse, long_press, key_id, busy);
    end
  endtask

  task automatic test_short_press();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_p;
      logic       exp_b;
      btn_clean = (k < 3) ? 4'b0010 : 4'b0000;
      step();
      exp_p = (k == 0) ? 4'b0010 : 4'b0000;
      exp_b = (k < 3);
      total++;
      if (key_pulse !== exp_p || long_press !== 1'b0 || busy !== exp_b ||
          key_id !== (exp_b ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL short_press k=%0d: got pulse=%b long=%b id=%0d busy=%b, want pulse=%b long=0 id=%0d busy=%b",
                 k, key_pulse, long_press, key_id, busy, exp_p, exp_b ? 1 : 0, exp_b);
      end
    end
  endtask

  task automatic test_long_repeat();
    for (int k = 0; k < 32; k++) begin
      logic [3:0] exp_p;
      logic       exp_l;
      logic       exp_b;
      btn_clean = (k < 30) ? 4'b0010 : 4'b0000;
      step();
      exp_p = ((k == 0) || (REP && k >= 12 && k <= 28 && (k % 4) == 0)) ? 4'b0010 : 4'b0000;
      exp_l = (k == 8);
      exp_b = (k < 30);
      total++;
      if (key_pulse !== exp_p || long_press !== exp_l || busy !== exp_b ||
          key_id !== (exp_b ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL long_repeat k=%0d: got pulse=%b long=%b id=%0d busy=%b, want pulse=%b long=%b id=%0d busy=%b",
                 k, key_pulse, long_press, key_id, busy, exp_p, exp_l, exp_b ? 1 : 0, exp_b);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_clean = 4'b1010;
    step();
    total++;
    if (key_pulse !== 4'b0010 || key_id !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL simul_arbit: got pulse=%b id=%0d busy=%b, want pulse=0010 id=1 busy=1",
               key_pulse, key_id, busy);
    end
    btn_clean = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (key_pulse !== 4'b0000 || long_press !== 1'b0 || busy !== 1'b0 || key_id !== 2'd0) begin
        bad++;
        $display("FAIL simul_ignore k=%0d: got pulse=%b long=%b id=%0d busy=%b, want all 0",
                 k, key_pulse, long_press, key_id, busy);
      end
    end
    btn_clean = 4'b0000;
    step();   // WAIT_REL -> IDLE
    btn_clean = 4'b1000;
    step();
    total++;
    if (key_pulse !== 4'b1000 || key_id !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL simul_repress: got pulse=%b id=%0d busy=%b, want pulse=1000 id=3 busy=1",
               key_pulse, key_id, busy);
    end
    btn_clean = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid_press();
    btn_clean = 4'b0001;
    step();   // S
    total++;
    if (key_pulse !== 4'b0001 || key_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_press: got pulse=%b id=%0d busy=%b, want pulse=0001 id=0 busy=1",
               key_pulse, key_id, busy);
    end
    for (int k = 1; k < 5; k++) step();
    total++;
    if (busy !== 1'b1 || long_press !== 1'b0) begin
      bad++;
      $display("FAIL midrst_before: got busy=%b long=%b, want busy=1 long=0", busy, long_press);
    end
    rst_n = 1'b0;
    step();   // S+5
    rst_n = 1'b1;
    total++;
    if ({key_pulse, long_press, key_id, busy} !== 8'h00) begin
      bad++;
      $display("FAIL midrst_reset: got pulse=%b long=%b id=%0d busy=%b, want all 0",
               key_pulse, long_press, key_id, busy);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      total++;
      if ({key_pulse, long_press, key_id, busy} !== 8'h00) begin
        bad++;
        $display("FAIL midrst_held k=%0d: got pulse=%b long=%b id=%0d busy=%b, want all 0",
                 k, key_pulse, long_press, key_id, busy);
      end
    end
    btn_clean = 4'b0000;
    step();   // -> IDLE
    btn_clean = 4'b0001;
    step();
    total++;
    if (key_pulse !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_repress: got pulse=%b busy=%b, want pulse=0001 busy=1", key_pulse, busy);
    end
    btn_clean = 4'b0000;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    btn_clean = 4'b1100;
    step();
    total++;
    if (key_pulse !== 4'b0100 || key_id !== 2'd2) begin
      bad++;
      $display("FAIL b2b_first: got pulse=%b id=%0d, want pulse=0100 id=2", key_pulse, key_id);
    end
    btn_clean = 4'b0000;
    step();   // -> WAIT_REL
    total++;
    if (busy !== 1'b0 || key_pulse !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_release: got busy=%b pulse=%b, want busy=0 pulse=0000", busy, key_pulse);
    end
    step();   // -> IDLE
    btn_clean = 4'b0001;
    step();
    total++;
    if (key_pulse !== 4'b0001 || key_id !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: got pulse=%b id=%0d busy=%b, want pulse=0001 id=0 busy=1",
               key_pulse, key_id, busy);
    end
    step();
    total++;
    if (key_pulse !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_one_cycle: got pulse=%b, want 0000", key_pulse);
    end
    btn_clean = 4'b0000;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    btn_clean = 4'b0000;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid_press();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
